// File: rtl/ir_bidir_counter.sv
// Doorway people counter: two IR beams, synchronised and debounced,
// decoded by a direction FSM into a saturating occupancy count.
module ir_bidir_counter #(
  parameter int WIDTH           = 10,
  parameter int MAX_COUNT       = 1023,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             beam_a,
  input  logic             beam_b,
  input  logic             enable,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             inc_pulse,
  output logic             dec_pulse,
  output logic             err_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DLIM = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);

  typedef enum logic [2:0] {
    S_IDLE, S_E1, S_E2, S_E3,
    S_X1, S_X2, S_X3, S_WAIT
  } state_t;

  logic [1:0]       r_s1, r_s2, r_f;
  logic [DW-1:0]    r_db [2];
  logic [TW-1:0]    r_to;
  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_inc, r_dec, r_err;

  state_t     w_nxt;
  logic [1:0] w_ab;
  logic       w_ferr, w_entry, w_exit, w_to;

  assign w_ab = {r_f[0], r_f[1]};
  assign w_to = (r_to == TLIM);

  // Bit 0 is beam A, bit 1 is beam B
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_f  <= '0;
      for (int i = 0; i < 2; i++) r_db[i] <= '0;
    end else begin
      r_s1 <= {beam_b, beam_a};
      r_s2 <= r_s1;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] != r_f[i]) begin
          if (r_db[i] == DLIM) begin
            r_f[i]  <= r_s2[i];
            r_db[i] <= '0;
          end else begin
            r_db[i] <= r_db[i] + DW'(1);
          end
        end else begin
          r_db[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_nxt   = r_state;
    w_ferr  = 1'b0;
    w_entry = 1'b0;
    w_exit  = 1'b0;
    unique case (r_state)
      S_IDLE:
        case (w_ab)
          2'b10: w_nxt = S_E1;
          2'b01: w_nxt = S_X1;
          2'b11: begin w_nxt = S_WAIT; w_ferr = 1'b1; end
          default: ;
        endcase
      S_E1:
        case (w_ab)
          2'b11: w_nxt = S_E2;
          2'b00: w_nxt = S_IDLE;
          2'b01: begin w_nxt = S_WAIT; w_ferr = 1'b1; end
          default: ;
        endcase
      S_E2:
        case (w_ab)
          2'b01: w_nxt = S_E3;
          2'b10: w_nxt = S_E1;
          2'b00: begin w_nxt = S_WAIT; w_ferr = 1'b1; end
          default: ;
        endcase
      S_E3:
        case (w_ab)
          2'b00: begin w_nxt = S_IDLE; w_entry = 1'b1; end
          2'b11: w_nxt = S_E2;
          2'b10: begin w_nxt = S_WAIT; w_ferr = 1'b1; end
          default: ;
        endcase
      S_X1:
        case (w_ab)
          2'b11: w_nxt = S_X2;
          2'b00: w_nxt = S_IDLE;
          2'b10: begin w_nxt = S_WAIT; w_ferr = 1'b1; end
          default: ;
        endcase
      S_X2:
        case (w_ab)
          2'b10: w_nxt = S_X3;
          2'b01: w_nxt = S_X1;
          2'b00: begin w_nxt = S_WAIT; w_ferr = 1'b1; end
          default: ;
        endcase
      S_X3:
        case (w_ab)
          2'b00: begin w_nxt = S_IDLE; w_exit = 1'b1; end
          2'b11: w_nxt = S_X2;
          2'b01: begin w_nxt = S_WAIT; w_ferr = 1'b1; end
          default: ;
        endcase
      S_WAIT:
        if (w_ab == 2'b00) w_nxt = S_IDLE;
    endcase
    // A stalled traversal is abandoned
    if (w_nxt == r_state && w_to &&
        r_state != S_IDLE && r_state != S_WAIT) begin
      w_nxt  = S_WAIT;
      w_ferr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_to    <= '0;
      r_count <= '0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state || r_state == S_IDLE ||
          r_state == S_WAIT)
        r_to <= '0;
      else
        r_to <= r_to + TW'(1);
      r_inc <= 1'b0;
      r_dec <= 1'b0;
      r_err <= w_ferr;
      if (clr) begin
        r_count <= '0;
      end else if (enable && w_entry) begin
        if (r_count < MAXV) begin
          r_count <= r_count + WIDTH'(1);
          r_inc   <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end else if (enable && w_exit) begin
        if (r_count != '0) begin
          r_count <= r_count - WIDTH'(1);
          r_dec   <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign count     = r_count;
  assign full      = (r_count == MAXV);
  assign empty     = (r_count == '0);
  assign inc_pulse = r_inc;
  assign dec_pulse = r_dec;
  assign err_pulse = r_err;

endmodule

// File: tb/tb_ir_bidir_counter.sv
// Directed bench for ir_bidir_counter with small parameters
// (debounce 4, timeout 100, max count 3, width 4).
module tb_ir_bidir_counter;

  logic       clk = 1'b0;
  logic       rst_n, beam_a, beam_b, enable, clr;
  logic [3:0] count;
  logic       full, empty, inc_pulse, dec_pulse, err_pulse;

  int n_chk = 0;
  int n_fail = 0;
  int n_inc = 0, n_dec = 0, n_err = 0;
  int s_inc, s_dec, s_err;
  logic [1:0] glitch_seen;

  ir_bidir_counter #(
    .WIDTH(4), .MAX_COUNT(3),
    .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .beam_a(beam_a), .beam_b(beam_b),
    .enable(enable), .clr(clr),
    .count(count), .full(full), .empty(empty),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inc_pulse === 1'b1) n_inc++;
    if (dec_pulse === 1'b1) n_dec++;
    if (err_pulse === 1'b1) n_err++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic a, input logic b, input int n);
    beam_a = a;
    beam_b = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_inc = n_inc;
    s_dec = n_dec;
    s_err = n_err;
  endtask

  task automatic entry();
    hold(1, 0, 10); hold(1, 1, 10);
    hold(0, 1, 10); hold(0, 0, 10);
  endtask

  task automatic exit_seq();
    hold(0, 1, 10); hold(1, 1, 10);
    hold(1, 0, 10); hold(0, 0, 10);
  endtask

  initial begin
    rst_n = 1'b0; beam_a = 1'b0; beam_b = 1'b0;
    enable = 1'b1; clr = 1'b0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: idle after reset
    hold(0, 0, 20);
    chk("idle_count", count, 0);
    chk("idle_empty", empty, 1);
    chk("idle_full", full, 0);
    chk("idle_pulses", n_inc + n_dec + n_err, 0);

    // 2: one entry, one exit
    snap();
    entry();
    chk("entry_inc", n_inc - s_inc, 1);
    chk("entry_count", count, 1);
    chk("entry_empty", empty, 0);
    exit_seq();
    chk("exit_dec", n_dec - s_dec, 1);
    chk("exit_count", count, 0);
    chk("exit_empty", empty, 1);

    // 3: short glitch on beam A is filtered
    snap();
    glitch_seen = 2'b00;
    beam_a = 1'b1;
    repeat (3) begin
      @(negedge clk) glitch_seen |= dut.r_f;
    end
    @(posedge clk) #1 beam_a = 1'b0;
    repeat (12) begin
      @(negedge clk) glitch_seen |= dut.r_f;
    end
    @(posedge clk) #1;
    chk("glitch_filter", glitch_seen, 0);
    chk("glitch_pulses", (n_inc - s_inc) + (n_err - s_err), 0);
    chk("glitch_count", count, 0);

    // 4: saturation at full and at empty
    entry(); chk("sat_c1", count, 1);
    entry(); chk("sat_c2", count, 2);
    entry(); chk("sat_c3", count, 3);
    chk("sat_full", full, 1);
    snap();
    entry();
    chk("sat_full_err", n_err - s_err, 1);
    chk("sat_full_noinc", n_inc - s_inc, 0);
    chk("sat_hold3", count, 3);
    exit_seq(); exit_seq(); exit_seq();
    chk("drain_count", count, 0);
    snap();
    exit_seq();
    chk("empty_err", n_err - s_err, 1);
    chk("empty_nodec", n_dec - s_dec, 0);
    chk("empty_hold0", count, 0);

    // both beams at once from idle is illegal
    snap();
    hold(1, 1, 10); hold(0, 0, 10);
    chk("illegal_err", n_err - s_err, 1);
    chk("illegal_count", count, 0);

    // 5: timeout with A held
    snap();
    hold(1, 0, 150);
    chk("timeout_err", n_err - s_err, 1);
    hold(0, 0, 20);
    chk("timeout_noinc", n_inc - s_inc, 0);
    entry();
    chk("after_to_count", count, 1);

    // 6: reset in the middle of an entry
    hold(1, 0, 10); hold(1, 1, 10);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    hold(0, 0, 5);
    rst_n = 1'b1;
    snap();
    hold(0, 0, 15);
    chk("postrst_count", count, 0);
    chk("postrst_pulses", n_inc - s_inc, 0);

    // clear coincident with entry completion
    entry();
    chk("pre_clr_count", count, 1);
    snap();
    hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
    beam_b = 1'b0;
    repeat (6) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    hold(0, 0, 5);
    chk("clr_count", count, 0);
    chk("clr_noinc", n_inc - s_inc, 0);
    chk("clr_noerr", n_err - s_err, 0);

    // enable low: traversal ignored, FSM still recovers
    enable = 1'b0;
    snap();
    entry();
    chk("dis_count", count, 0);
    chk("dis_noinc", n_inc - s_inc, 0);
    enable = 1'b1;
    entry();
    chk("reen_count", count, 1);
    chk("reen_inc", n_inc - s_inc, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
